// File: rtl/spectro_timing_gen_pkg.sv
// Shared encodings and default timing constants for the line-sensor timing generator.
// The ADC capture block imports the same constants so that its pixel framing agrees with this block.
package spectro_timing_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_INTEG   = 2'd1,
    S_READOUT = 2'd2
  } state_e;

  localparam int CLK_DIV_DEF       = 8;
  localparam int CNT_W_DEF         = 16;
  localparam int ST_MIN_DEF        = 6;
  localparam int TRIG_OFFSET_DEF   = 82;
  localparam int PIXELS_DEF        = 288;
  localparam int READOUT_TICKS_DEF = 375;

endpackage

// File: rtl/spectro_timing_gen_sclk_divider.sv
// Free-running SCLK divider: registered 50% sclk, tick on the last div count (SCLK fall),
// rise strobe on the first high div count (SCLK rise).
module spectro_timing_gen_sclk_divider #(
  parameter int CLK_DIV = 8,
  parameter int DIV_W   = $clog2(CLK_DIV)
) (
  input  logic clk,
  input  logic resetn,
  output logic sclk,
  output logic tick,
  output logic rise
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] HALF = DIV_W'(CLK_DIV / 2);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_n;

  assign tick = (div == LAST);
  assign rise = (div == HALF);

  always_comb begin
    div_n = tick ? '0 : div + DIV_W'(1);
  end

  // sclk is computed from the next count so that the register matches div in the same cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      div  <= '0;
      sclk <= 1'b0;
    end else begin
      div  <= div_n;
      sclk <= (div_n >= HALF);
    end
  end

endmodule

// File: rtl/spectro_timing_gen.sv
// C12880-class line-sensor timing generator: SST integration pulse, OTRIG, per-pixel ADC strobes,
// single-shot or back-to-back continuous frames. All frame state advances on SCLK falling edges.
module spectro_timing_gen
  import spectro_timing_gen_pkg::*;
#(
  parameter int CLK_DIV       = CLK_DIV_DEF,
  parameter int CNT_W         = CNT_W_DEF,
  parameter int ST_MIN        = ST_MIN_DEF,
  parameter int TRIG_OFFSET   = TRIG_OFFSET_DEF,
  parameter int PIXELS        = PIXELS_DEF,
  parameter int READOUT_TICKS = READOUT_TICKS_DEF
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  input  logic                      continuous,
  input  logic [CNT_W-1:0]          integ_len,
  output logic                      sclk,
  output logic                      sst,
  output logic                      otrig,
  output logic                      pix_valid,
  output logic [$clog2(PIXELS)-1:0] pix_index,
  output logic                      busy,
  output logic                      frame_done,
  output logic [15:0]               frame_cnt,
  output state_e                    state_dbg
);

  localparam int PIX_W = $clog2(PIXELS);
  localparam logic [CNT_W-1:0] ST_MIN_C  = CNT_W'(ST_MIN);
  localparam logic [CNT_W-1:0] TRIG_C    = CNT_W'(TRIG_OFFSET);
  localparam logic [CNT_W-1:0] PIX_END_C = CNT_W'(TRIG_OFFSET + PIXELS);
  localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(READOUT_TICKS - 1);

  logic tick, rise;

  spectro_timing_gen_sclk_divider #(.CLK_DIV(CLK_DIV)) u_sclk_divider (
    .clk    (clk),
    .resetn (resetn),
    .sclk   (sclk),
    .tick   (tick),
    .rise   (rise)
  );

  state_e           state, state_n;
  logic             pending, pending_n;
  logic [CNT_W-1:0] len, len_n;
  logic [CNT_W-1:0] icnt, icnt_n;
  logic [CNT_W-1:0] rcnt, rcnt_n;
  logic [15:0]      frame_cnt_n;
  logic [CNT_W-1:0] len_clamped;
  logic             in_window;
  logic             frame_end;

  assign len_clamped = (integ_len < ST_MIN_C) ? ST_MIN_C : integ_len;
  assign in_window   = (state == S_READOUT) && (rcnt >= TRIG_C) && (rcnt < PIX_END_C);
  assign frame_end   = (state == S_READOUT) && (rcnt == LAST_C) && tick;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      pending   <= 1'b0;
      len       <= '0;
      icnt      <= '0;
      rcnt      <= '0;
      frame_cnt <= '0;
    end else begin
      state     <= state_n;
      pending   <= pending_n;
      len       <= len_n;
      icnt      <= icnt_n;
      rcnt      <= rcnt_n;
      frame_cnt <= frame_cnt_n;
    end
  end

  // start is a 1-clk request honoured only in IDLE (held as pending until the next tick);
  // pix_valid is a 1-clk strobe without back-pressure and pix_index is meaningful only while it is 1.
  always_comb begin
    state_n     = state;
    pending_n   = pending;
    len_n       = len;
    icnt_n      = icnt;
    rcnt_n      = rcnt;
    frame_cnt_n = frame_cnt;
    if (state == S_IDLE && start) pending_n = 1'b1;
    if (tick) begin
      case (state)
        S_IDLE: begin
          if (pending) begin
            state_n   = S_INTEG;
            pending_n = 1'b0;
            len_n     = len_clamped;
            icnt_n    = '0;
          end
        end
        S_INTEG: begin
          if (icnt == len - CNT_W'(1)) begin
            state_n = S_READOUT;
            rcnt_n  = '0;
          end else begin
            icnt_n = icnt + CNT_W'(1);
          end
        end
        S_READOUT: begin
          if (rcnt == LAST_C) begin
            frame_cnt_n = frame_cnt + 16'd1;
            // continuous is only looked at here, so mid-frame changes wait for the frame end
            if (continuous) begin
              state_n = S_INTEG;
              len_n   = len_clamped;
              icnt_n  = '0;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            rcnt_n = rcnt + CNT_W'(1);
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  assign sst        = (state == S_INTEG);
  assign busy       = (state != S_IDLE);
  assign otrig      = (state == S_READOUT) && (rcnt == TRIG_C);
  assign pix_valid  = in_window && rise;
  assign pix_index  = in_window ? PIX_W'(rcnt - TRIG_C) : '0;
  assign frame_done = frame_end;
  assign state_dbg  = state;

endmodule

// File: tb/tb_spectro_timing_gen.sv
// Directed bench for spectro_timing_gen at CLK_DIV=8 with default timing constants.
module tb_spectro_timing_gen;
  import spectro_timing_gen_pkg::*;

  localparam int PIXELS = 288;
  localparam int PIX_W  = 9;

  logic             clk = 1'b0;
  logic             resetn;
  logic             start;
  logic             continuous;
  logic [15:0]      integ_len;
  logic             sclk, sst, otrig, pix_valid, busy, frame_done;
  logic [PIX_W-1:0] pix_index;
  logic [15:0]      frame_cnt;
  state_e           state_dbg;

  spectro_timing_gen dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .continuous (continuous),
    .integ_len  (integ_len),
    .sclk       (sclk),
    .sst        (sst),
    .otrig      (otrig),
    .pix_valid  (pix_valid),
    .pix_index  (pix_index),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .state_dbg  (state_dbg)
  );

  // clock/reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;
  int exp_frames = 0;
  int t_start = 0;

  // monitor / scoreboard state
  logic [PIX_W-1:0] exp_q[$];
  int sst_rise_q[$];
  int otrig_rise_q[$];
  int done_q[$];
  int sst_clks, otrig_clks, pix_cnt, pix_err, edge_err, pix_first;
  logic prev_sst = 1'b0, prev_otrig = 1'b0, prev_sclk = 1'b0;
  logic [PIX_W-1:0] exp_idx;

  always @(negedge clk) begin
    if (!resetn) begin
      exp_q.delete();
    end else begin
      if (sst) sst_clks++;
      if (sst != prev_sst) begin
        if (sst) sst_rise_q.push_back(cyc);
        if (!(sclk == 1'b0 && prev_sclk == 1'b1)) edge_err++;
      end
      if (otrig) otrig_clks++;
      if (otrig && !prev_otrig) begin
        otrig_rise_q.push_back(cyc);
        for (int i = 0; i < PIXELS; i++) exp_q.push_back(PIX_W'(i));
      end
      if (pix_valid) begin
        pix_cnt++;
        if (pix_first < 0) pix_first = int'(pix_index);
        if (exp_q.size() == 0) pix_err++;
        else begin
          exp_idx = exp_q.pop_front();
          if (pix_index != exp_idx) pix_err++;
        end
        if (!(sclk == 1'b1 && prev_sclk == 1'b0)) pix_err++;
      end
      if (frame_done) done_q.push_back(cyc);
    end
    prev_sst   = sst;
    prev_otrig = otrig;
    prev_sclk  = sclk;
  end

  task automatic clear_stats();
    sst_clks = 0; otrig_clks = 0; pix_cnt = 0; pix_err = 0; edge_err = 0; pix_first = -1;
    sst_rise_q.delete(); otrig_rise_q.delete(); done_q.delete(); exp_q.delete();
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [15:0] len, input logic cont);
    @(negedge clk);
    integ_len  = len;
    continuous = cont;
    start      = 1'b1;
    t_start    = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit start_on_done, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (frame_done) begin
        ok = 1'b1;
        if (start_on_done) start = 1'b1;
      end
    end
    if (start_on_done && ok) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  typedef struct {
    logic [15:0] integ_len;
    int          exp_sst_clks;
    int          exp_otrig_ofs;
    int          exp_frame_clks;
  } vec_t;

  vec_t vecs[5];

  initial begin
    bit ok;
    bit found;
    int bad, quiet, sr, lat;
    logic hist[100];

    vecs[0] = '{16'd6,    48,   704,  3048};
    vecs[1] = '{16'd2,    48,   704,  3048};
    vecs[2] = '{16'd0,    48,   704,  3048};
    vecs[3] = '{16'd10,   80,   736,  3080};
    vecs[4] = '{16'd1000, 8000, 8656, 11000};

    resetn = 1'b0; start = 1'b0; continuous = 1'b0; integ_len = 16'd6;
    clear_stats();
    idle(3);
    check("reset_outputs", {sclk, sst, otrig, pix_valid, busy, frame_done}, 0);
    check("reset_frame_cnt", frame_cnt, 0);
    check("reset_state", state_dbg, S_IDLE);
    resetn = 1'b1;

    // idle: sclk period 8 clks, everything else quiet
    bad = 0; quiet = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      hist[i] = sclk;
      if (i >= 4 && hist[i] == hist[i-4]) bad++;
      if (sst || otrig || pix_valid || busy || frame_done) quiet++;
    end
    check("idle_sclk_toggle", bad, 0);
    check("idle_quiet", quiet, 0);
    check("idle_frame_cnt", frame_cnt, 0);

    // single-shot frames across integration lengths
    for (int v = 0; v < 5; v++) begin
      @(posedge clk);
      clear_stats();
      pulse_start(vecs[v].integ_len, 1'b0);
      wait_done(12000, 1'b0, ok);
      check("done_seen", ok, 1);
      exp_frames++;
      idle(4);
      sr  = (sst_rise_q.size() > 0) ? sst_rise_q[0] : -100000;
      lat = sr - t_start;
      check("start_latency_in_2_9", (lat >= 2 && lat <= 9), 1);
      check("sst_clks", sst_clks, vecs[v].exp_sst_clks);
      check("otrig_clks", otrig_clks, 8);
      check("otrig_ofs", (otrig_rise_q.size() > 0) ? otrig_rise_q[0] - sr : -1, vecs[v].exp_otrig_ofs);
      check("frame_clks", (done_q.size() > 0) ? done_q[0] - sr + 1 : -1, vecs[v].exp_frame_clks);
      check("pix_cnt", pix_cnt, PIXELS);
      check("pix_err", pix_err, 0);
      check("edge_align", edge_err, 0);
      check("done_cnt", done_q.size(), 1);
      check("frame_cnt", frame_cnt, exp_frames);
      check("busy_after", busy, 0);
    end

    // continuous: three back-to-back frames, continuous dropped mid-frame 3
    @(posedge clk);
    clear_stats();
    pulse_start(16'd6, 1'b1);
    wait_done(4000, 1'b0, ok);
    check("cont_done1", ok, 1);
    wait_done(4000, 1'b0, ok);
    check("cont_done2", ok, 1);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (sst_rise_q.size() >= 3) found = 1'b1;
    end
    check("cont_third_sst", found, 1);
    idle(50);
    continuous = 1'b0;
    wait_done(4000, 1'b0, ok);
    check("cont_done3", ok, 1);
    exp_frames += 3;
    idle(100);
    check("cont_frames", done_q.size(), 3);
    check("cont_sst_rises", sst_rise_q.size(), 3);
    check("cont_gap1", (sst_rise_q.size() > 1 && done_q.size() > 0) ? sst_rise_q[1] - done_q[0] : -1, 1);
    check("cont_gap2", (sst_rise_q.size() > 2 && done_q.size() > 1) ? sst_rise_q[2] - done_q[1] : -1, 1);
    check("cont_pix_cnt", pix_cnt, 3 * PIXELS);
    check("cont_pix_err", pix_err, 0);
    check("cont_frame_cnt", frame_cnt, exp_frames);
    check("cont_busy_after", busy, 0);

    // reset at pixel 100, then a fresh frame
    @(posedge clk);
    clear_stats();
    pulse_start(16'd6, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 6000 && !found; i++) begin
      @(negedge clk);
      if (pix_valid && pix_index == 9'd100) found = 1'b1;
    end
    check("rst_pix100_seen", found, 1);
    resetn = 1'b0;
    @(negedge clk);
    check("rst_outputs", {sclk, sst, otrig, pix_valid, busy, frame_done}, 0);
    check("rst_pix_index", pix_index, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    exp_frames = 0;
    idle(3);
    check("rst_no_done", done_q.size(), 0);
    resetn = 1'b1;
    @(posedge clk);
    clear_stats();
    pulse_start(16'd6, 1'b0);
    wait_done(4000, 1'b0, ok);
    check("rst_done_seen", ok, 1);
    exp_frames++;
    idle(4);
    check("rst_first_pix", pix_first, 0);
    check("rst_pix_cnt", pix_cnt, PIXELS);
    check("rst_pix_err", pix_err, 0);
    check("rst_frame_cnt_after", frame_cnt, exp_frames);

    // starts while busy and on the frame_done cycle are ignored
    @(posedge clk);
    clear_stats();
    pulse_start(16'd6, 1'b0);
    idle(20);
    pulse_start(16'd6, 1'b0);
    idle(1000);
    pulse_start(16'd6, 1'b0);
    wait_done(4000, 1'b1, ok);
    check("busy_done_seen", ok, 1);
    exp_frames++;
    idle(400);
    check("busy_sst_rises", sst_rise_q.size(), 1);
    check("busy_done_cnt", done_q.size(), 1);
    check("busy_after", busy, 0);
    check("busy_frame_cnt", frame_cnt, exp_frames);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
